ram_loader_mar: RTL and testbench

Memory address register and program-mode loader sitting directly upstream of the 16x8 RAM. It drives the RAM's address, write-enable and write-data inputs. In run mode it behaves as the classic MAR: it latches the bus low nibble and passes bus data and the control-unit write strobe through to the RAM. In program mode it accepts a valid/ready byte stream (from a switch panel or serial front end) and writes it sequentially into RAM locations 0..15.

---
 rtl/ram_loader_pkg.sv | 17 +
 rtl/ram_loader_mar_sync2.sv | 28 ++
 rtl/ram_loader_mar.sv | 127 ++++++++++++
 tb/tb_ram_loader_mar.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the MAR / program-mode loader.
// Holds the loader FSM state enum, the RAM depth and default bus widths.
// No logic; imported by ram_loader_mar.
package ram_loader_pkg;

  localparam int RAM_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    PROG_IDLE  = 2'd1,
    PROG_WRITE = 2'd2,
    PROG_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_loader_mar_sync2.sv
// Generic 2-flop synchronizer for asynchronous front-panel switch inputs.
// Latency: 2 clock edges from i_d to o_q. No backpressure.
// Ports: i_clk, i_rst_n (async active-low), i_d (async input), o_q (synchronized).
module sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_ff1;
  logic [W-1:0] r_ff2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff1 <= '0;
      r_ff2 <= '0;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/ram_loader_mar.sv
// Memory address register plus program-mode byte loader in front of a 16x8 RAM.
// Latency: run mode is combinational pass-through; loader writes a byte 1 cycle after acceptance.
// Backpressure: Load_Ready drops for the write cycle (1 byte / 2 cycles) and stays low once all 16 locations are loaded.
// Ports: CLK, Reset_N, Prog_Mode (async switch), MAR_Load/Run_Write_Enable/Bus_In (run mode),
//        Load_Valid/Load_Data/Load_Ready (byte stream), Load_Done, Checksum, RAM_* (to RAM), MAR_DISP.
// Optional feature: define LOADER_CHECKSUM_EN to build the mod-256 checksum accumulator; otherwise Checksum is 0.
module ram_loader_mar
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              Reset_N,
  input  logic              Prog_Mode,
  input  logic              MAR_Load,
  input  logic              Run_Write_Enable,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic              Load_Valid,
  input  logic [DATA_W-1:0] Load_Data,
  output logic              Load_Ready,
  output logic              Load_Done,
  output logic [DATA_W-1:0] Checksum,
  output logic [ADDR_W-1:0] RAM_Address,
  output logic              RAM_Write_Enable,
  output logic [DATA_W-1:0] RAM_Data,
  output logic [ADDR_W-1:0] MAR_DISP
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_byte;
  logic              w_pm_s;
  logic              w_accept;
  logic              w_clear;
  logic              w_cnt_inc;
  logic              w_run;

  sync2 #(.W(1)) u_pm_sync (
    .i_clk   (CLK),
    .i_rst_n (Reset_N),
    .i_d     (Prog_Mode),
    .o_q     (w_pm_s)
  );

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_pm_s) begin
          w_state_nxt = PROG_IDLE;
          w_clear     = 1'b1;
        end
      end
      PROG_IDLE: begin
        // An offered byte wins over a falling pm_s: it is taken and written.
        if (Load_Valid) begin
          w_accept    = 1'b1;
          w_state_nxt = PROG_WRITE;
        end else if (!w_pm_s) begin
          w_state_nxt = RUN;
        end
      end
      PROG_WRITE: begin
        // Counter parks at the last address; it never wraps.
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = PROG_DONE;
        end else begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = w_pm_s ? PROG_IDLE : RUN;
        end
      end
      PROG_DONE: begin
        if (!w_pm_s) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      r_mar  <= '0;
      r_cnt  <= '0;
      r_byte <= '0;
    end else begin
      if (r_state == RUN && MAR_Load) r_mar <= Bus_In[ADDR_W-1:0];
      if (w_clear)        r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_accept) r_byte <= Load_Data;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N)      r_csum <= '0;
    else if (w_clear)  r_csum <= '0;
    else if (w_accept) r_csum <= r_csum + Load_Data;
  end

  assign Checksum = r_csum;
`else
  assign Checksum = '0;
`endif

  assign w_run            = (r_state == RUN);
  assign Load_Ready       = (r_state == PROG_IDLE);
  assign Load_Done        = (r_state == PROG_DONE);
  assign RAM_Address      = w_run ? r_mar : r_cnt;
  assign RAM_Write_Enable = w_run ? Run_Write_Enable : (r_state == PROG_WRITE);
  assign RAM_Data         = w_run ? Bus_In : r_byte;
  assign MAR_DISP         = r_mar;

endmodule

// File: tb/tb_ram_loader_mar.sv
module tb_ram_loader_mar;

  logic       CLK = 1'b0;
  logic       Reset_N;
  logic       Prog_Mode;
  logic       MAR_Load;
  logic       Run_Write_Enable;
  logic [7:0] Bus_In;
  logic       Load_Valid;
  logic [7:0] Load_Data;
  logic       Load_Ready;
  logic       Load_Done;
  logic [7:0] Checksum;
  logic [3:0] RAM_Address;
  logic       RAM_Write_Enable;
  logic [7:0] RAM_Data;
  logic [3:0] MAR_DISP;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  ram_loader_mar dut (
    .CLK              (CLK),
    .Reset_N          (Reset_N),
    .Prog_Mode        (Prog_Mode),
    .MAR_Load         (MAR_Load),
    .Run_Write_Enable (Run_Write_Enable),
    .Bus_In           (Bus_In),
    .Load_Valid       (Load_Valid),
    .Load_Data        (Load_Data),
    .Load_Ready       (Load_Ready),
    .Load_Done        (Load_Done),
    .Checksum         (Checksum),
    .RAM_Address      (RAM_Address),
    .RAM_Write_Enable (RAM_Write_Enable),
    .RAM_Data         (RAM_Data),
    .MAR_DISP         (MAR_DISP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits at negedges until Load_Ready rises; bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!Load_Ready && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  // Entered at a negedge with Load_Ready=1; offers one byte, checks the write cycle.
  task automatic load_byte(input logic [7:0] d, input logic [3:0] a);
    Load_Data  = d;
    Load_Valid = 1'b1;
    @(negedge CLK);
    check("wr_we",    {31'd0, RAM_Write_Enable}, 32'd1);
    check("wr_addr",  {28'd0, RAM_Address}, {28'd0, a});
    check("wr_data",  {24'd0, RAM_Data}, {24'd0, d});
    check("wr_ready", {31'd0, Load_Ready}, 32'd0);
    Load_Data = ~d;  // changes while not ready; must never be written
    @(negedge CLK);
    check("post_we", {31'd0, RAM_Write_Enable}, 32'd0);
    if (a != 4'hF) check("post_ready", {31'd0, Load_Ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int wr;
    logic [7:0] sum;

    Reset_N = 1'b0; Prog_Mode = 1'b0; MAR_Load = 1'b0; Run_Write_Enable = 1'b0;
    Bus_In = 8'h00; Load_Valid = 1'b0; Load_Data = 8'h00;

    // Reset values
    @(negedge CLK);
    check("rst_addr",  {28'd0, RAM_Address}, 32'd0);
    check("rst_we",    {31'd0, RAM_Write_Enable}, 32'd0);
    check("rst_data",  {24'd0, RAM_Data}, 32'd0);
    check("rst_mar",   {28'd0, MAR_DISP}, 32'd0);
    check("rst_ready", {31'd0, Load_Ready}, 32'd0);
    check("rst_done",  {31'd0, Load_Done}, 32'd0);
    check("rst_csum",  {24'd0, Checksum}, 32'd0);
    Reset_N = 1'b1;

    // Run mode MAR load and pass-through
    @(negedge CLK);
    Bus_In = 8'h3A; MAR_Load = 1'b1;
    @(negedge CLK);
    MAR_Load = 1'b0;
    check("mar_disp", {28'd0, MAR_DISP}, 32'hA);
    check("mar_addr", {28'd0, RAM_Address}, 32'hA);
    Run_Write_Enable = 1'b1;
    #1;
    check("run_we",   {31'd0, RAM_Write_Enable}, 32'd1);
    check("run_data", {24'd0, RAM_Data}, 32'h3A);
    @(negedge CLK);
    Run_Write_Enable = 1'b0;
    #1;
    check("run_we_off", {31'd0, RAM_Write_Enable}, 32'd0);

    // Full 16-byte load with Load_Valid held high
    @(negedge CLK);
    Prog_Mode = 1'b1;
    wait_ready(lat);
    check("pm_entry_lat", {31'd0, (lat >= 2 && lat <= 3)}, 32'd1);
    check("ld_addr0", {28'd0, RAM_Address}, 32'd0);
    for (int i = 0; i < 16; i++) load_byte(8'(i), 4'(i));
    check("done",       {31'd0, Load_Done}, 32'd1);
    check("done_ready", {31'd0, Load_Ready}, 32'd0);
    check("done_csum",  {24'd0, Checksum}, CS_EN ? 32'h78 : 32'h0);

    // PROG_DONE ignores further bytes
    Load_Valid = 1'b1; Load_Data = 8'h55;
    wr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (RAM_Write_Enable) wr++;
    end
    check("done_nowr",  wr, 0);
    check("done_hold",  {31'd0, Load_Done}, 32'd1);
    check("done_addr",  {28'd0, RAM_Address}, 32'hF);
    Load_Valid = 1'b0;

    // Exit to RUN, MAR unchanged, MAR_Load works again
    Prog_Mode = 1'b0;
    lat = 0;
    while (Load_Done && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    check("exit_lat",  {31'd0, (lat <= 3)}, 32'd1);
    check("exit_mar",  {28'd0, RAM_Address}, 32'hA);
    check("exit_csum", {24'd0, Checksum}, CS_EN ? 32'h78 : 32'h0);
    Bus_In = 8'h57; MAR_Load = 1'b1;
    @(negedge CLK);
    MAR_Load = 1'b0;
    check("reload_mar", {28'd0, MAR_DISP}, 32'h7);

    // Partial load then abort
    Prog_Mode = 1'b1;
    wait_ready(lat);
    check("re_ready", {31'd0, Load_Ready}, 32'd1);
    check("re_csum0", {24'd0, Checksum}, 32'd0);
    sum = 8'h00;
    for (int i = 0; i < 5; i++) begin
      load_byte(8'h10 + 8'(i), 4'(i));
      sum = sum + 8'h10 + 8'(i);
    end
    Load_Valid = 1'b0;
    check("part_csum", {24'd0, Checksum}, CS_EN ? {24'd0, sum} : 32'h0);
    Prog_Mode = 1'b0;
    lat = 0; wr = 0;
    while (Load_Ready && lat < 10) begin
      @(negedge CLK);
      lat++;
      if (RAM_Write_Enable) wr++;
    end
    check("abort_lat",  {31'd0, (lat <= 3)}, 32'd1);
    check("abort_nowr", wr, 0);
    check("abort_done", {31'd0, Load_Done}, 32'd0);
    check("abort_addr", {28'd0, RAM_Address}, 32'h7);
    check("abort_mar",  {28'd0, MAR_DISP}, 32'h7);

    // Re-entry restarts at address 0 with cleared checksum
    Prog_Mode = 1'b1;
    wait_ready(lat);
    check("re2_ready", {31'd0, Load_Ready}, 32'd1);
    check("re2_addr",  {28'd0, RAM_Address}, 32'd0);
    check("re2_csum",  {24'd0, Checksum}, 32'd0);

    // Reset during PROG_WRITE
    Bus_In = 8'h00;
    Load_Data = 8'hC3; Load_Valid = 1'b1;
    @(negedge CLK);
    check("pre_rst_we", {31'd0, RAM_Write_Enable}, 32'd1);
    Load_Valid = 1'b0;
    #1 Reset_N = 1'b0;
    #1;
    check("mid_rst_we",    {31'd0, RAM_Write_Enable}, 32'd0);
    check("mid_rst_ready", {31'd0, Load_Ready}, 32'd0);
    check("mid_rst_done",  {31'd0, Load_Done}, 32'd0);
    check("mid_rst_addr",  {28'd0, RAM_Address}, 32'd0);
    check("mid_rst_mar",   {28'd0, MAR_DISP}, 32'd0);
    check("mid_rst_data",  {24'd0, RAM_Data}, 32'd0);
    check("mid_rst_csum",  {24'd0, Checksum}, 32'd0);
    Prog_Mode = 1'b0;
    @(negedge CLK);
    Reset_N = 1'b1;
    repeat (4) @(negedge CLK);
    check("post_rst_ready", {31'd0, Load_Ready}, 32'd0);
    Bus_In = 8'h05; MAR_Load = 1'b1;
    @(negedge CLK);
    MAR_Load = 1'b0;
    check("post_rst_mar",  {28'd0, MAR_DISP}, 32'h5);
    check("post_rst_addr", {28'd0, RAM_Address}, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
